// File: rtl/mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg : shared types and constants for the memory burst controller
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  localparam int RD_FIFO_DEPTH  = 4;
  localparam int MEM_RD_LATENCY = 2;

endpackage : mem_ctrl_pkg

`default_nettype wire

// File: rtl/mem_rd_fifo.sv
// ---------------------------------------------------------------------------
// mem_rd_fifo : small synchronous FIFO buffering memory read returns
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_rd_fifo
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = RD_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [DATA_WIDTH-1:0]      data_i,
  input  logic                       pop_i,
  output logic [DATA_WIDTH-1:0]      data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     occ_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [AW:0]           cnt_q;
  logic                  push_ok;
  logic                  pop_ok;

  assign pop_ok  = pop_i && (cnt_q != '0);
  assign push_ok = push_i && ((cnt_q != C_FULL) || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (cnt_q != '0);
  assign occ_o   = cnt_q;

endmodule : mem_rd_fifo

`default_nettype wire

// File: rtl/mem_burst_ctrl.sv
// ---------------------------------------------------------------------------
// mem_burst_ctrl : burst initiator streaming write/read beats to reg_mem
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_burst_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_BITS-1:0]  cmd_addr_i,
  input  logic [ADDR_BITS-1:0]  cmd_len_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic                  done_o,
  output logic [ADDR_BITS-1:0]  mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_in_o,
  output logic                  mem_wen_o,
  input  logic [DATA_WIDTH-1:0] mem_data_out_i
);

  localparam int FIFO_AW = $clog2(RD_FIFO_DEPTH);
  localparam logic [FIFO_AW+1:0]  C_DEPTH  = (FIFO_AW+2)'(RD_FIFO_DEPTH);
  localparam logic [ADDR_BITS-1:0] C_A_ONE = ADDR_BITS'(1);
  localparam logic [ADDR_BITS:0]   C_I_ONE = (ADDR_BITS+1)'(1);

  state_e                  state_q;
  logic [ADDR_BITS-1:0]    addr_q;
  logic [ADDR_BITS-1:0]    len_q;
  logic [ADDR_BITS-1:0]    beat_q;
  logic [ADDR_BITS:0]      issued_q;
  logic [ADDR_BITS-1:0]    mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_data_in_q;
  logic                    mem_wen_q;
  logic                    done_q;
  logic [MEM_RD_LATENCY-1:0] pipe_v_q;

  logic [FIFO_AW:0]        fifo_occ;
  logic                    fifo_valid;
  logic [DATA_WIDTH-1:0]   fifo_data;
  logic [FIFO_AW+1:0]      inflight;
  logic [FIFO_AW+1:0]      outstanding;
  logic                    rd_issue;
  logic                    rd_hs;
  logic                    wr_hs;

  // In-flight reads: one bit per pipeline stage between issue and FIFO push.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_RD_LATENCY; i++) begin
      inflight = inflight + (FIFO_AW+2)'(pipe_v_q[i]);
    end
  end

  assign outstanding = {1'b0, fifo_occ} + inflight;
  assign rd_issue    = (state_q == READ) && (issued_q <= {1'b0, len_q}) &&
                       (outstanding < C_DEPTH);
  assign rd_hs       = fifo_valid && rd_ready_i;
  assign wr_hs       = (state_q == WRITE) && wr_valid_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      issued_q      <= '0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      mem_wen_q     <= 1'b0;
      done_q        <= 1'b0;
      pipe_v_q      <= '0;
    end else begin
      done_q    <= 1'b0;
      mem_wen_q <= 1'b0;
      pipe_v_q  <= {pipe_v_q[MEM_RD_LATENCY-2:0], rd_issue};
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            addr_q   <= cmd_addr_i;
            len_q    <= cmd_len_i;
            beat_q   <= '0;
            issued_q <= '0;
            state_q  <= cmd_write_i ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_hs) begin
            mem_addr_q    <= addr_q;
            mem_data_in_q <= wr_data_i;
            mem_wen_q     <= 1'b1;
            addr_q        <= addr_q + C_A_ONE;
            beat_q        <= beat_q + C_A_ONE;
            if (beat_q == len_q) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        READ: begin
          if (rd_issue) begin
            mem_addr_q <= addr_q;
            addr_q     <= addr_q + C_A_ONE;
            issued_q   <= issued_q + C_I_ONE;
          end
          if (rd_hs) begin
            beat_q <= beat_q + C_A_ONE;
            if (beat_q == len_q) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mem_rd_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RD_FIFO_DEPTH)
  ) u_rd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (pipe_v_q[MEM_RD_LATENCY-1]),
    .data_i  (mem_data_out_i),
    .pop_i   (rd_hs),
    .data_o  (fifo_data),
    .valid_o (fifo_valid),
    .occ_o   (fifo_occ)
  );

  assign cmd_ready_o   = (state_q == IDLE);
  assign wr_ready_o    = (state_q == WRITE);
  assign rd_valid_o    = fifo_valid;
  assign rd_data_o     = fifo_data;
  assign done_o        = done_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_data_in_o = mem_data_in_q;
  assign mem_wen_o     = mem_wen_q;

endmodule : mem_burst_ctrl

`default_nettype wire
